// File: rtl/ball_controller.sv
// Ball motion controller for a brick-breaker playfield of 16x16 cells.
// Tracks the ball position and direction, bounces it off walls, bricks and
// the paddle, and runs the serve / lost-ball / game-over sequence.
module ball_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic        move_tick,
    input  logic        start,
    input  logic [3:0]  paddle_col,
    input  logic [55:0] Bricks,
    output logic [3:0]  Ball_rowIndex,
    output logic [3:0]  Ball_colIndex,
    output logic [1:0]  Ball_direction,
    output logic [1:0]  lives,
    output logic        game_over,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        LOST = 2'b10,
        OVER = 2'b11
    } state_t;

    state_t st;

    // Brick presence at a cell; only rows 0..6 carry bricks, two columns per brick.
    function automatic logic brick_at(input logic [3:0] r, input logic [3:0] c,
                                      input logic [55:0] map);
        brick_at = (r <= 4'd6) && map[{r[2:0], c[3:1]}];
    endfunction

    // One-cell step that saturates at the playfield edge instead of wrapping.
    function automatic logic [3:0] step_sat(input logic [3:0] v, input logic inc);
        if (inc)
            step_sat = (v == 4'd15) ? v : v + 4'd1;
        else
            step_sat = (v == 4'd0) ? v : v - 4'd1;
    endfunction

    logic [3:0] pc;
    logic [3:0] home_col;
    logic       dx_pos;
    logic       dy_pos;
    logic       at_side;
    logic       at_top;
    logic [3:0] c_nb;
    logic [3:0] r_nb;
    logic       on_paddle;
    logic       hflip;
    logic       vflip;
    logic       corner;
    logic [1:0] new_dir;
    logic [3:0] new_row;
    logic [3:0] new_col;

    // Paddle clamp and the serve position the ball rests on while idle.
    always_comb begin
        pc       = (paddle_col > 4'd12) ? 4'd12 : paddle_col;
        home_col = pc + 4'd1;
    end

    // Collision detection and next-position computation for one move.
    always_comb begin
        dx_pos    = Ball_direction[0];
        dy_pos    = Ball_direction[1];
        // Edge tests come first; the neighbour cells are only meaningful when
        // the ball is not already against that edge.
        at_side   = dx_pos ? (Ball_colIndex == 4'd15) : (Ball_colIndex == 4'd0);
        at_top    = !dy_pos && (Ball_rowIndex == 4'd0);
        c_nb      = dx_pos ? Ball_colIndex + 4'd1 : Ball_colIndex - 4'd1;
        r_nb      = dy_pos ? Ball_rowIndex + 4'd1 : Ball_rowIndex - 4'd1;
        on_paddle = dy_pos && (Ball_rowIndex == 4'd14) &&
                    (Ball_colIndex >= pc) && (Ball_colIndex <= pc + 4'd3);
        hflip     = at_side || brick_at(Ball_rowIndex, c_nb, Bricks);
        vflip     = at_top || on_paddle || brick_at(r_nb, Ball_colIndex, Bricks);
        // Diagonal-only contact reverses both axes.
        corner    = !hflip && !vflip && brick_at(r_nb, c_nb, Bricks);
        new_dir   = {Ball_direction[1] ^ (vflip || corner),
                     Ball_direction[0] ^ (hflip || corner)};
        new_row   = step_sat(Ball_rowIndex, new_dir[1]);
        new_col   = step_sat(Ball_colIndex, new_dir[0]);
    end

    // Game FSM with registered ball position, direction, lives and game_over.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st             <= IDLE;
            lives          <= 2'd3;
            Ball_direction <= 2'b01;
            Ball_rowIndex  <= 4'd14;
            Ball_colIndex  <= 4'd1;
            game_over      <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    Ball_rowIndex  <= 4'd14;
                    Ball_direction <= 2'b01;
                    if (move_tick && start)
                        st <= RUN;
                    else
                        Ball_colIndex <= home_col;
                end
                RUN: begin
                    if (move_tick) begin
                        Ball_direction <= new_dir;
                        Ball_rowIndex  <= new_row;
                        Ball_colIndex  <= new_col;
                        if (new_row == 4'd15)
                            st <= LOST;
                    end
                end
                LOST: begin
                    if (move_tick) begin
                        lives <= lives - 2'd1;
                        if (lives == 2'd1) begin
                            st        <= OVER;
                            game_over <= 1'b1;
                        end else begin
                            st             <= IDLE;
                            Ball_rowIndex  <= 4'd14;
                            Ball_colIndex  <= home_col;
                            Ball_direction <= 2'b01;
                        end
                    end
                end
                OVER: begin
                    if (move_tick && start) begin
                        st             <= IDLE;
                        lives          <= 2'd3;
                        game_over      <= 1'b0;
                        Ball_rowIndex  <= 4'd14;
                        Ball_colIndex  <= home_col;
                        Ball_direction <= 2'b01;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_ball_controller.sv
// Directed testbench for ball_controller: walks the ball along hand-traced
// trajectories and checks position, direction, state and lives.
module tb_ball_controller;

    logic        clock;
    logic        reset;
    logic        move_tick;
    logic        start;
    logic [3:0]  paddle_col;
    logic [55:0] Bricks;
    logic [3:0]  Ball_rowIndex;
    logic [3:0]  Ball_colIndex;
    logic [1:0]  Ball_direction;
    logic [1:0]  lives;
    logic        game_over;
    logic [1:0]  state;

    int tests;
    int fails;

    ball_controller dut (
        .clock          (clock),
        .reset          (reset),
        .move_tick      (move_tick),
        .start          (start),
        .paddle_col     (paddle_col),
        .Bricks         (Bricks),
        .Ball_rowIndex  (Ball_rowIndex),
        .Ball_colIndex  (Ball_colIndex),
        .Ball_direction (Ball_direction),
        .lives          (lives),
        .game_over      (game_over),
        .state          (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ball(input string tag, input logic [3:0] r, input logic [3:0] c,
                            input logic [1:0] d);
        chk({tag, " row"}, {4'd0, Ball_rowIndex}, {4'd0, r});
        chk({tag, " col"}, {4'd0, Ball_colIndex}, {4'd0, c});
        chk({tag, " dir"}, {6'd0, Ball_direction}, {6'd0, d});
    endtask

    task automatic chk_game(input string tag, input logic [1:0] s, input logic [1:0] l,
                            input logic g);
        chk({tag, " state"}, {6'd0, state}, {6'd0, s});
        chk({tag, " lives"}, {6'd0, lives}, {6'd0, l});
        chk({tag, " game_over"}, {7'd0, game_over}, {7'd0, g});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One move_tick pulse; returns on the following falling edge.
    task automatic do_tick(input logic st_req);
        @(negedge clock);
        move_tick = 1'b1;
        start     = st_req;
        @(negedge clock);
        move_tick = 1'b0;
        start     = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) do_tick(1'b0);
    endtask

    task automatic serve(input logic [3:0] p);
        paddle_col = p;
        wait_cycles(2);
        do_tick(1'b1);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        reset      = 1'b1;
        move_tick  = 1'b0;
        start      = 1'b0;
        paddle_col = 4'd0;
        Bricks     = '0;

        // Reset state
        @(negedge clock);
        chk_ball("reset", 4'd14, 4'd1, 2'b01);
        chk_game("reset", 2'b00, 2'd3, 1'b0);
        reset = 1'b0;

        // Idle tracking, paddle clamp, start ignored without tick
        paddle_col = 4'd15;
        wait_cycles(2);
        chk("idle clamp col", {4'd0, Ball_colIndex}, 8'd13);
        paddle_col = 4'd5;
        wait_cycles(2);
        chk_ball("idle p5", 4'd14, 4'd6, 2'b01);
        start = 1'b1;
        wait_cycles(2);
        start = 1'b0;
        chk("start no tick state", {6'd0, state}, 8'd0);

        // Serve then first move
        do_tick(1'b1);
        chk("serve state", {6'd0, state}, 8'd1);
        chk_ball("serve", 4'd14, 4'd6, 2'b01);
        do_tick(1'b0);
        chk_ball("first move", 4'd13, 4'd7, 2'b01);
        wait_cycles(3);
        chk_ball("hold no tick", 4'd13, 4'd7, 2'b01);

        // Asynchronous reset while running
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk_ball("async reset", 4'd14, 4'd1, 2'b01);
        chk_game("async reset", 2'b00, 2'd3, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // Right-wall bounce, ceiling bounce, left-wall bounce, then a miss
        serve(4'd3);
        paddle_col = 4'd10;
        ticks(11);
        chk_ball("to wall", 4'd3, 4'd15, 2'b01);
        do_tick(1'b0);
        chk_ball("right wall", 4'd2, 4'd14, 2'b00);
        ticks(2);
        chk_ball("to ceiling", 4'd0, 4'd12, 2'b00);
        do_tick(1'b0);
        chk_ball("ceiling", 4'd1, 4'd11, 2'b10);
        ticks(11);
        chk_ball("to left wall", 4'd12, 4'd0, 2'b10);
        do_tick(1'b0);
        chk_ball("left wall", 4'd13, 4'd1, 2'b11);
        do_tick(1'b0);
        chk_ball("above paddle", 4'd14, 4'd2, 2'b11);
        do_tick(1'b0);
        chk_ball("missed", 4'd15, 4'd3, 2'b11);
        chk_game("lost1", 2'b10, 2'd3, 1'b0);
        wait_cycles(2);
        chk("lost hold state", {6'd0, state}, 8'd2);
        do_tick(1'b0);
        chk_game("after loss1", 2'b00, 2'd2, 1'b0);
        chk_ball("after loss1", 4'd14, 4'd11, 2'b01);

        // Second loss: top-right corner hit, then miss at column 1
        serve(4'd0);
        paddle_col = 4'd10;
        ticks(14);
        chk_ball("to corner", 4'd0, 4'd15, 2'b01);
        do_tick(1'b0);
        chk_ball("corner", 4'd1, 4'd14, 2'b10);
        ticks(14);
        chk_ball("miss2", 4'd15, 4'd0, 2'b10);
        chk("lost2 state", {6'd0, state}, 8'd2);
        do_tick(1'b0);
        chk_game("after loss2", 2'b00, 2'd1, 1'b0);

        // Third loss ends the game
        serve(4'd0);
        paddle_col = 4'd10;
        ticks(29);
        chk("lost3 state", {6'd0, state}, 8'd2);
        do_tick(1'b0);
        chk_game("over", 2'b11, 2'd0, 1'b1);
        chk_ball("over hold", 4'd15, 4'd0, 2'b10);
        do_tick(1'b0);
        chk("over no start", {6'd0, state}, 8'd3);
        paddle_col = 4'd2;
        do_tick(1'b1);
        chk_game("restart", 2'b00, 2'd3, 1'b0);
        chk_ball("restart", 4'd14, 4'd3, 2'b01);

        // Brick above while rising, paddle return, left wall, ceiling at (0,4)
        serve(4'd1);
        paddle_col = 4'd8;
        ticks(9);
        chk_ball("to brick37", 4'd5, 4'd11, 2'b01);
        Bricks = 56'd1 << 37;
        do_tick(1'b0);
        chk_ball("brick37", 4'd6, 4'd12, 2'b11);
        Bricks = '0;
        ticks(8);
        chk_ball("to paddle", 4'd14, 4'd10, 2'b10);
        do_tick(1'b0);
        chk_ball("paddle hit", 4'd13, 4'd9, 2'b00);
        ticks(13);
        chk_ball("at 0,4", 4'd0, 4'd4, 2'b01);
        do_tick(1'b0);
        chk_ball("top bounce", 4'd1, 4'd5, 2'b11);

        // Brick bit 52 on the way up and on the way back, clamped paddle corner
        pulse_reset();
        paddle_col = 4'd0;
        Bricks = 56'd1 << 52;
        serve(4'd0);
        paddle_col = 4'd14;
        ticks(7);
        chk_ball("to 7,8 up", 4'd7, 4'd8, 2'b01);
        do_tick(1'b0);
        chk_ball("brick52 up", 4'd8, 4'd9, 2'b11);
        ticks(6);
        chk_ball("paddle corner", 4'd14, 4'd15, 2'b11);
        do_tick(1'b0);
        chk_ball("clamped paddle", 4'd13, 4'd14, 2'b00);
        ticks(6);
        chk_ball("at 7,8", 4'd7, 4'd8, 2'b00);
        do_tick(1'b0);
        chk_ball("brick52", 4'd8, 4'd7, 2'b10);
        chk("brick52 state", {6'd0, state}, 8'd1);

        // Paddle return at (14,9)
        pulse_reset();
        Bricks = 56'd1 << 29;
        serve(4'd0);
        paddle_col = 4'd8;
        ticks(10);
        chk_ball("to brick29", 4'd4, 4'd11, 2'b01);
        do_tick(1'b0);
        chk_ball("brick29", 4'd5, 4'd12, 2'b11);
        Bricks = '0;
        ticks(4);
        chk_ball("right wall down", 4'd9, 4'd14, 2'b10);
        ticks(5);
        chk_ball("at 14,9", 4'd14, 4'd9, 2'b10);
        do_tick(1'b0);
        chk_ball("paddle 14,9", 4'd13, 4'd8, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
